// File: rtl/instr_fetch_queue_pkg.sv
// instr_fetch_queue_pkg
//   Shared constants and small helpers for the instruction fetch queue.
//   XLEN        : instruction and PC width
//   FETCH_WIDTH : maximum number of instructions per fetch bundle / decode group
//   NOP_INSTR   : canonical NOP (addi x0, x0, 0) shown on empty decode slots
package instr_fetch_queue_pkg;

  localparam int          XLEN        = 32;
  localparam int          FETCH_WIDTH = 2;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  // A fetch count of 3 cannot be stored in a dual-issue bundle, so it is
  // treated as a full bundle of two.
  function automatic logic [1:0] bundleCount(input logic [1:0] cnt);
    return (cnt == 2'd3) ? 2'd2 : cnt;
  endfunction

  // Decode may never retire more entries than are actually present.
  function automatic logic [1:0] clampTake(input logic [1:0] take,
                                           input logic [1:0] avail);
    return (take > avail) ? avail : take;
  endfunction

endpackage

// File: rtl/ifq_storage.sv
// ifq_storage
//   DEPTH-entry register array for the fetch queue, two write ports and two
//   combinational read ports. Contents are never reset; the owner tracks which
//   entries are valid.
//   clk           : clock
//   wr_en0_i/1_i  : per-port write enable
//   wr_idx0_i/1_i : write index
//   wr_data0_i/1_i: write data
//   rd_idx0_i/1_i : read index
//   rd_data0_o/1_o: read data
module ifq_storage #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en0_i,
  input  logic [$clog2(DEPTH)-1:0] wr_idx0_i,
  input  logic [WIDTH-1:0]         wr_data0_i,
  input  logic                     wr_en1_i,
  input  logic [$clog2(DEPTH)-1:0] wr_idx1_i,
  input  logic [WIDTH-1:0]         wr_data1_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx0_i,
  output logic [WIDTH-1:0]         rd_data0_o,
  input  logic [$clog2(DEPTH)-1:0] rd_idx1_i,
  output logic [WIDTH-1:0]         rd_data1_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // The two write indices are always consecutive slots, so they never collide.
  always_ff @(posedge clk) begin
    if (wr_en0_i) begin
      mem_q[wr_idx0_i] <= wr_data0_i;
    end
    if (wr_en1_i) begin
      mem_q[wr_idx1_i] <= wr_data1_i;
    end
  end

  assign rd_data0_o = mem_q[rd_idx0_i];
  assign rd_data1_o = mem_q[rd_idx1_i];

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Dual-issue instruction fetch queue between the fetch port and decode.
//   Accepts bundles of 1-2 instructions with their PC, presents the oldest two
//   entries to decode, and drops everything on a redirect flush.
//   clk, reset      : clock, synchronous active-high reset
//   flush           : drop all entries (branch redirect), beats enqueue/dequeue
//   fetch_valid/rdy : bundle handshake; ready means at least two free slots
//   fetch_cnt       : bundle size (0 no-op, 3 treated as 2)
//   fetch_pc        : PC of fetch_instr0; fetch_instr1 sits at fetch_pc + 4
//   fetch_instr0/1  : older / younger instruction
//   dec_valid0/1    : head / head+1 valid
//   dec_instr0/1    : head / head+1 instruction, NOP when invalid
//   dec_pc0/1       : head / head+1 PC, 0 when invalid
//   dec_take        : entries consumed by decode this cycle
//   occupancy       : current entry count
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = instr_fetch_queue_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [1:0]               fetch_cnt,
  input  logic [XLEN-1:0]          fetch_pc,
  input  logic [XLEN-1:0]          fetch_instr0,
  input  logic [XLEN-1:0]          fetch_instr1,
  output logic                     dec_valid0,
  output logic                     dec_valid1,
  output logic [XLEN-1:0]          dec_instr0,
  output logic [XLEN-1:0]          dec_instr1,
  output logic [XLEN-1:0]          dec_pc0,
  output logic [XLEN-1:0]          dec_pc1,
  input  logic [1:0]               dec_take,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 * XLEN;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FW_C    = CNT_W'(FETCH_WIDTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] occ_q,  occ_d;

  logic [CNT_W-1:0] freeSlots;
  logic             acceptBundle;
  logic [1:0]       enqCnt;
  logic [1:0]       validCnt;
  logic [1:0]       deqCnt;

  logic             wrEn0, wrEn1;
  logic [PTR_W-1:0] wrIdx1, rdIdx1;
  logic [ENT_W-1:0] wrData0, wrData1;
  logic [ENT_W-1:0] rdData0, rdData1;

  // Ready is derived from the registered count only; entries leaving in the
  // same cycle do not make room for an incoming bundle.
  assign freeSlots    = DEPTH_C - occ_q;
  assign fetch_ready  = (freeSlots >= FW_C);
  assign acceptBundle = fetch_valid & fetch_ready & ~flush & ~reset;
  assign enqCnt       = acceptBundle ? bundleCount(fetch_cnt) : 2'd0;

  // Entries decode can see this cycle: at most two.
  assign validCnt = (occ_q >= CNT_W'(2)) ? 2'd2 : occ_q[1:0];
  assign deqCnt   = clampTake(dec_take, validCnt);

  // Each entry holds {pc, instr}; the younger slot's PC is implied by the bundle.
  assign wrEn0   = (enqCnt != 2'd0);
  assign wrEn1   = (enqCnt == 2'd2);
  assign wrIdx1  = tail_q + PTR_W'(1);
  assign wrData0 = {fetch_pc, fetch_instr0};
  assign wrData1 = {fetch_pc + XLEN'(4), fetch_instr1};
  assign rdIdx1  = head_q + PTR_W'(1);

  ifq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_storage (
    .clk        (clk),
    .wr_en0_i   (wrEn0),
    .wr_idx0_i  (tail_q),
    .wr_data0_i (wrData0),
    .wr_en1_i   (wrEn1),
    .wr_idx1_i  (wrIdx1),
    .wr_data1_i (wrData1),
    .rd_idx0_i  (head_q),
    .rd_data0_o (rdData0),
    .rd_idx1_i  (rdIdx1),
    .rd_data1_o (rdData1)
  );

  // Pointer and count update. Flush wins over any enqueue or dequeue and
  // returns the queue to empty; pointers wrap naturally at DEPTH.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      head_d = head_q + PTR_W'(deqCnt);
      tail_d = tail_q + PTR_W'(enqCnt);
      occ_d  = occ_q + CNT_W'(enqCnt) - CNT_W'(deqCnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Decode view: combinational read of head and head+1, masked when empty.
  always_comb begin
    dec_valid0 = (validCnt != 2'd0);
    dec_valid1 = (validCnt == 2'd2);
    dec_instr0 = XLEN'(NOP_INSTR);
    dec_instr1 = XLEN'(NOP_INSTR);
    dec_pc0    = '0;
    dec_pc1    = '0;
    if (dec_valid0) begin
      dec_instr0 = rdData0[XLEN-1:0];
      dec_pc0    = rdData0[ENT_W-1:XLEN];
    end
    if (dec_valid1) begin
      dec_instr1 = rdData1[XLEN-1:0];
      dec_pc1    = rdData1[ENT_W-1:XLEN];
    end
  end

  assign occupancy = occ_q;

`ifndef SYNTHESIS
  // Decode consuming more than it was shown is a protocol error upstream.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (dec_take <= validCnt)
        else $error("instr_fetch_queue: dec_take %0d exceeds valid count %0d",
                    dec_take, validCnt);
    end
  end
`endif

endmodule
